// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier share arbiter.
// Holds the FSM state encoding, stat width and round-robin search.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Returns {found, index}: first set bit at or after ptr, wrapping at n.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [IDX_W:0] res;
    int k;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !res[IDX_W] && req[k[IDX_W-1:0]])
        res = {1'b1, k[IDX_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_arb_rr_pick.sv
// Combinational round-robin picker for the multiplier arbiter.
// Produces a one-hot grant and the binary index of the winner.
module mul_arb_rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   ptr_ext;
  logic [IDX_W:0]     pick;

  // Widen to the package search width, then decode the winner
  always_comb begin
    req_ext = MAX_REQ'(req);
    ptr_ext = IDX_W'(ptr);
    pick    = rr_pick(req_ext, ptr_ext, NUM_REQ);
    found   = pick[IDX_W];
    idx     = ID_W'(pick[IDX_W-1:0]);
    gnt     = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among requesters.
// Optional MUL_ARB_STATS_EN adds saturating stat_ops/stat_stall ports.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [A_W+B_W-1:0]     rsp_product,
  output logic                   busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_ops,
  output logic [STAT_W-1:0]      stat_stall
`endif
);

  localparam int P_W = A_W + B_W;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [A_W-1:0]     op_a;
  logic [B_W-1:0]     op_b;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win;
  logic               found;
  logic [A_W-1:0]     sel_a;
  logic [B_W-1:0]     sel_b;
  logic [P_W-1:0]     prod;
  logic               hs;

  mul_arb_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .idx  (win),
    .found(found)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign prod      = P_W'(op_a) * P_W'(op_b);
  assign hs        = rsp_valid & rsp_ready;

  // Route the winner's operands to the operand latches
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
      end
    end
  end

  // Accept -> multiply -> hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            rsp_id <= win;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          rsp_product <= prod;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            if (rsp_id == ID_W'(NUM_REQ - 1))
              rr_ptr <= '0;
            else
              rr_ptr <= rsp_id + ID_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef MUL_ARB_STATS_EN
  // Saturating counts of completed operations and stalled response cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (hs && stat_ops != '1)
        stat_ops <= stat_ops + STAT_W'(1);
      if (state == RESP && !rsp_ready && stat_stall != '1)
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule
